bkram_sd_ctrl: RTL and testbench
================================

// Module: bkram_sd_ctrl
// PURPOSE
//  Moves battery-backed cart RAM between on-chip backup RAM and the mounted SD image, one 512-byte sector at a time.
//  Generalised in size, LBA base and sector count; adds dirty tracking, autosave, queued requests, short-image clamp and an ack watchdog.
//  Sits between user_io (sd_* handshake) and the dpram B port of the nvram in the core top level.
// PARAMETERS
//  SECT_W     4   log2 of backup sectors (4 -> 16 x 512 B = 8 KB)
//  LBA_BASE   0   first image LBA used for backup data
//  AUTOSAVE   0   1: rising autosave_trig while dirty starts a save
//  TMO_W      20  watchdog width; abort after 2^TMO_W cycles without an ack edge
// PORTS
//  clk_sys       in   1          system clock
//  RESET_n       in   1          async active-low reset
//  img_mounted   in   1          level from user_io; rising edge = new image
//  img_size      in   32         image size in bytes
//  img_readonly  in   1          image is write-protected
//  bk_disable    in   1          pulse: forget image (ROM download start)
//  load_req      in   1          level; rising edge requests a load
//  save_req      in   1          level; rising edge requests a save
//  autosave_trig in   1          level; rising edge = autosave point (OSD close)
//  dirty_in      in   1          core wrote nvram this cycle
//  sd_lba        out  32         sector address to user_io
//  sd_rd         out  1          read request
//  sd_wr         out  1          write request
//  sd_ack        in   1          user_io sector ack (high for the whole transfer)
//  sd_buff_addr  in   9          byte index within the sector
//  sd_buff_wr    in   1          byte strobe from SD (load direction)
//  bk_addr       out  SECT_W+9   nvram port-B address = {sector, sd_buff_addr}
//  bk_we         out  1          nvram port-B write enable
//  bk_ena        out  1          valid image mounted
//  bk_busy       out  1          transfer in progress
//  bk_dirty      out  1          nvram differs from image
//  bk_reset      out  1          one-cycle pulse after a load completes
//  bk_err        out  1          sticky: short image, write-protected save, or timeout
// BEHAVIOUR
//  - Reset: all outputs 0, sd_lba=LBA_BASE, state IDLE, pending flags clear.
//  - Edges: one-cycle registered detectors on img_mounted, load_req, save_req, autosave_trig and sd_ack.
//  - Mount rise, img_size==0: bk_ena=0.
//  - Mount rise, img_size>0: bk_ena=1, nsect=min(2^SECT_W, ceil(img_size/512)), queue a load.
//    bk_err=1 if nsect < 2^SECT_W.
//  - bk_disable: bk_ena=0, pending cleared. A transfer already running finishes normally.
//  - States: IDLE -> REQ -> XFER -> NEXT -> (REQ | DONE) -> IDLE; ABORT reached from REQ or XFER.
//  - IDLE: takes pending load first, else pending save (only if bk_ena).
//    On start: sect=0, sd_lba=LBA_BASE, bk_busy=1.
//    Save start clears bk_dirty.
//  - REQ: sd_rd=load, sd_wr=~load; both drop on sd_ack rise; -> XFER.
//  - XFER: on sd_ack fall -> NEXT.
//  - NEXT: if sect==nsect-1 -> DONE, else sect++, sd_lba++, -> REQ.
//  - DONE: bk_busy=0. After a load, bk_reset pulses one cycle and bk_dirty=0.
//  - bk_addr={sect, sd_buff_addr}, combinational.
//  - bk_we = sd_buff_wr & sd_ack & loading, combinational.
//  - Save data is taken from the nvram q_b output; this block only steers the address.
//  - Watchdog: counter resets on every sd_ack edge and on every REQ entry.
//    Overflow -> ABORT: sd_rd=sd_wr=0, bk_err=1, bk_busy=0, pending cleared.
//    An aborted save re-sets bk_dirty.
//  - Save request with img_readonly: dropped, bk_err=1, bk_dirty kept.
//  - dirty_in sets bk_dirty when not loading, including during a save; wins over the save-start clear in the same cycle.
//  - Request during busy: latched as pending and run after DONE (one deep per direction).
//    Load and save pending together: load first, then the save is discarded (nvram now equals the image).
//  - AUTOSAVE=1: autosave_trig rise with bk_dirty & bk_ena & ~img_readonly queues a save.
//  - Mid-op reset: async clear; user_io sees sd_rd/sd_wr low immediately.
// STRUCTURE
//  - Package bkram_pkg: state enum, SECTOR_BYTES=512, SECTOR_AW=9.
//  - Sub-module bk_watchdog (TMO_W counter, clr/en in, expire out).
//  - FSM and pending logic stay in this module.
// TESTING
//  1 Mount 8 KB image, SECT_W=4 -> 16 reads, lba 0..15, 8192 bk_we strobes, one bk_reset, bk_busy falls.
//  2 Mount 1536 B image -> nsect=3, reads lba 0..2, bk_err=1, bk_ena=1.
//  3 dirty_in then save_req, LBA_BASE=32 -> 16 writes lba 32..47; bk_dirty clears at start.
//    A second dirty_in mid-save leaves bk_dirty=1 at DONE.
//  4 save_req while a load is running -> save starts after DONE; no bk_we during the save.
//    load+save same cycle -> load only.
//  5 sd_ack held low, TMO_W=6 -> ABORT after 64 cycles, sd_rd=0, bk_err=1, bk_busy=0.
//  6 img_readonly=1 and save_req -> no sd_wr, bk_err=1. AUTOSAVE=1, dirty, trig rise -> save runs.
//    RESET_n low mid-transfer -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/bkram_pkg.sv
// Shared types and constants for the backup-RAM <-> SD sector mover.
package bkram_pkg;

    localparam int SECTOR_BYTES = 512;
    localparam int SECTOR_AW    = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_NEXT,
        ST_DONE,
        ST_ABORT
    } bk_state_e;

    // Number of whole-or-partial sectors an image of sz bytes occupies.
    function automatic logic [23:0] size_to_sectors(input logic [31:0] sz);
        return 24'((33'(sz) + 33'(SECTOR_BYTES - 1)) >> SECTOR_AW);
    endfunction

endpackage

// File: rtl/bkram_sd_ctrl_if.sv
// Sector handshake between the backup controller (master) and user_io (slave).
interface bkram_sd_ctrl_if;
    import bkram_pkg::*;

    logic [31:0]          sd_lba;
    logic                 sd_rd;
    logic                 sd_wr;
    logic                 sd_ack;
    logic [SECTOR_AW-1:0] sd_buff_addr;
    logic                 sd_buff_wr;

    modport master (
        output sd_lba, sd_rd, sd_wr,
        input  sd_ack, sd_buff_addr, sd_buff_wr
    );

    modport slave (
        input  sd_lba, sd_rd, sd_wr,
        output sd_ack, sd_buff_addr, sd_buff_wr
    );

endinterface

// File: rtl/bk_watchdog.sv
// Free-running ack watchdog: expires after 2^TMO_W enabled cycles without a clear.
module bk_watchdog #(
    parameter int TMO_W = 20
) (
    input  logic clk_sys,
    input  logic RESET_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [TMO_W-1:0] cnt_q, cnt_d;

    // Clear has priority; count only while a transfer is waiting on the SD side.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + TMO_W'(1);
    end

    // Counter register.
    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expire_o = en_i & ~clr_i & (&cnt_q);

endmodule

// File: rtl/bkram_sd_ctrl.sv
// Backup-RAM sector mover: loads/saves battery RAM from/to the mounted SD image,
// with dirty tracking, optional autosave, one-deep request queues and a watchdog.
module bkram_sd_ctrl
    import bkram_pkg::*;
#(
    parameter int          SECT_W   = 4,
    parameter int unsigned LBA_BASE = 0,
    parameter int          AUTOSAVE = 0,
    parameter int          TMO_W    = 20
) (
    input  logic                        clk_sys,
    input  logic                        RESET_n,
    input  logic                        img_mounted,
    input  logic [31:0]                 img_size,
    input  logic                        img_readonly,
    input  logic                        bk_disable,
    input  logic                        load_req,
    input  logic                        save_req,
    input  logic                        autosave_trig,
    input  logic                        dirty_in,
    bkram_sd_ctrl_if.master             sd,
    output logic [SECT_W+SECTOR_AW-1:0] bk_addr,
    output logic                        bk_we,
    output logic                        bk_ena,
    output logic                        bk_busy,
    output logic                        bk_dirty,
    output logic                        bk_reset,
    output logic                        bk_err
);

    localparam int NW        = SECT_W + 1;
    localparam int NSECT_MAX = 1 << SECT_W;

    bk_state_e         state_q, state_d;
    logic              mnt_q, ld_q, sv_q, at_q, ack_q;
    logic              pend_ld_q, pend_ld_d, pend_sv_q, pend_sv_d;
    logic              dir_ld_q, dir_ld_d;
    logic [SECT_W-1:0] sect_q, sect_d;
    logic [NW-1:0]     nsect_q, nsect_d;
    logic [31:0]       lba_q, lba_d;
    logic              ena_q, ena_d;
    logic              busy_q, busy_d;
    logic              dirty_q, dirty_d;
    logic              rst_pulse_q, rst_pulse_d;
    logic              err_q, err_d;

    logic        mnt_rise, ld_rise, sv_rise, at_rise, ack_rise, ack_fall;
    logic        auto_evt, loading, wd_en, wd_clr, wd_expire;
    logic [23:0] img_sect;

    assign mnt_rise = img_mounted & ~mnt_q;
    assign ld_rise  = load_req & ~ld_q;
    assign sv_rise  = save_req & ~sv_q;
    assign at_rise  = autosave_trig & ~at_q;
    assign ack_rise = sd.sd_ack & ~ack_q;
    assign ack_fall = ~sd.sd_ack & ack_q;

    assign img_sect = size_to_sectors(img_size);
    assign loading  = busy_q & dir_ld_q;
    assign auto_evt = (AUTOSAVE != 0) & at_rise & dirty_q & ena_q & ~img_readonly;

    // Watchdog runs only while waiting on user_io; it is held clear in every
    // other state, so each REQ entry starts from zero.
    assign wd_en  = (state_q == ST_REQ) | (state_q == ST_XFER);
    assign wd_clr = ack_rise | ack_fall | ~wd_en;

    bk_watchdog #(.TMO_W(TMO_W)) u_wd (
        .clk_sys  (clk_sys),
        .RESET_n  (RESET_n),
        .clr_i    (wd_clr),
        .en_i     (wd_en),
        .expire_o (wd_expire)
    );

    // Next-state: FSM first, then request capture, then disable, then dirty
    // marking, so later items override earlier ones in the same cycle.
    always_comb begin
        state_d     = state_q;
        pend_ld_d   = pend_ld_q;
        pend_sv_d   = pend_sv_q;
        dir_ld_d    = dir_ld_q;
        sect_d      = sect_q;
        nsect_d     = nsect_q;
        lba_d       = lba_q;
        ena_d       = ena_q;
        busy_d      = busy_q;
        dirty_d     = dirty_q;
        rst_pulse_d = 1'b0;
        err_d       = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (ena_q && (pend_ld_q || pend_sv_q)) begin
                    sect_d  = '0;
                    lba_d   = 32'(LBA_BASE);
                    busy_d  = 1'b1;
                    state_d = ST_REQ;
                    if (pend_ld_q) begin
                        // A load makes any queued save pointless.
                        dir_ld_d  = 1'b1;
                        pend_ld_d = 1'b0;
                        pend_sv_d = 1'b0;
                    end else begin
                        dir_ld_d  = 1'b0;
                        pend_sv_d = 1'b0;
                        dirty_d   = 1'b0;
                    end
                end
            end
            ST_REQ: begin
                if (ack_rise)
                    state_d = ST_XFER;
                else if (wd_expire)
                    state_d = ST_ABORT;
            end
            ST_XFER: begin
                if (ack_fall)
                    state_d = ST_NEXT;
                else if (wd_expire)
                    state_d = ST_ABORT;
            end
            ST_NEXT: begin
                if ({1'b0, sect_q} == nsect_q - NW'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    sect_d  = sect_q + SECT_W'(1);
                    lba_d   = lba_q + 32'd1;
                    state_d = ST_REQ;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
                if (dir_ld_q) begin
                    rst_pulse_d = 1'b1;
                    dirty_d     = 1'b0;
                end
            end
            ST_ABORT: begin
                busy_d    = 1'b0;
                err_d     = 1'b1;
                pend_ld_d = 1'b0;
                pend_sv_d = 1'b0;
                state_d   = ST_IDLE;
                // The image was only partly written, so RAM still differs from it.
                if (!dir_ld_q)
                    dirty_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (mnt_rise) begin
            if (img_size == 32'd0) begin
                ena_d = 1'b0;
            end else begin
                ena_d     = 1'b1;
                pend_ld_d = 1'b1;
                if (img_sect < 24'(NSECT_MAX)) begin
                    nsect_d = NW'(img_sect);
                    err_d   = 1'b1;
                end else begin
                    nsect_d = NW'(NSECT_MAX);
                end
            end
        end

        if (ld_rise)
            pend_ld_d = 1'b1;

        if (sv_rise && img_readonly)
            err_d = 1'b1;
        else if (sv_rise || auto_evt)
            pend_sv_d = 1'b1;

        if (bk_disable) begin
            ena_d     = 1'b0;
            pend_ld_d = 1'b0;
            pend_sv_d = 1'b0;
        end

        if (dirty_in && !loading)
            dirty_d = 1'b1;
    end

    // State and edge-history registers.
    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q     <= ST_IDLE;
            mnt_q       <= 1'b0;
            ld_q        <= 1'b0;
            sv_q        <= 1'b0;
            at_q        <= 1'b0;
            ack_q       <= 1'b0;
            pend_ld_q   <= 1'b0;
            pend_sv_q   <= 1'b0;
            dir_ld_q    <= 1'b0;
            sect_q      <= '0;
            nsect_q     <= NW'(NSECT_MAX);
            lba_q       <= 32'(LBA_BASE);
            ena_q       <= 1'b0;
            busy_q      <= 1'b0;
            dirty_q     <= 1'b0;
            rst_pulse_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mnt_q       <= img_mounted;
            ld_q        <= load_req;
            sv_q        <= save_req;
            at_q        <= autosave_trig;
            ack_q       <= sd.sd_ack;
            pend_ld_q   <= pend_ld_d;
            pend_sv_q   <= pend_sv_d;
            dir_ld_q    <= dir_ld_d;
            sect_q      <= sect_d;
            nsect_q     <= nsect_d;
            lba_q       <= lba_d;
            ena_q       <= ena_d;
            busy_q      <= busy_d;
            dirty_q     <= dirty_d;
            rst_pulse_q <= rst_pulse_d;
            err_q       <= err_d;
        end
    end

    // Requests are decoded from the registered state so reset drops them at once.
    assign sd.sd_rd  = (state_q == ST_REQ) &  dir_ld_q;
    assign sd.sd_wr  = (state_q == ST_REQ) & ~dir_ld_q;
    assign sd.sd_lba = lba_q;

    assign bk_addr  = {sect_q, sd.sd_buff_addr};
    assign bk_we    = sd.sd_buff_wr & sd.sd_ack & loading;
    assign bk_ena   = ena_q;
    assign bk_busy  = busy_q;
    assign bk_dirty = dirty_q;
    assign bk_reset = rst_pulse_q;
    assign bk_err   = err_q;

endmodule

// File: tb/tb_bkram_sd_ctrl.sv
// Scoreboard bench for bkram_sd_ctrl: expected SD requests are queued by the
// stimulus, a monitor pops them as the DUT raises sd_rd/sd_wr.
module tb_bkram_sd_ctrl;
    import bkram_pkg::*;

    localparam int SECT_W    = 4;
    localparam int LBA_BASE  = 32;
    localparam int TMO_W     = 10;
    localparam int NSECT_MAX = 16;

    logic        clk_sys = 1'b0;
    logic        RESET_n = 1'b0;
    logic        img_mounted = 1'b0;
    logic [31:0] img_size = 32'd0;
    logic        img_readonly = 1'b0;
    logic        bk_disable = 1'b0;
    logic        load_req = 1'b0;
    logic        save_req = 1'b0;
    logic        autosave_trig = 1'b0;
    logic        dirty_in = 1'b0;
    logic [SECT_W+8:0] bk_addr;
    logic        bk_we, bk_ena, bk_busy, bk_dirty, bk_reset, bk_err;

    bkram_sd_ctrl_if sd_if();

    bkram_sd_ctrl #(.SECT_W(SECT_W), .LBA_BASE(LBA_BASE), .AUTOSAVE(1), .TMO_W(TMO_W)) dut (
        .clk_sys(clk_sys), .RESET_n(RESET_n), .img_mounted(img_mounted), .img_size(img_size),
        .img_readonly(img_readonly), .bk_disable(bk_disable), .load_req(load_req),
        .save_req(save_req), .autosave_trig(autosave_trig), .dirty_in(dirty_in),
        .sd(sd_if.master), .bk_addr(bk_addr), .bk_we(bk_we), .bk_ena(bk_ena),
        .bk_busy(bk_busy), .bk_dirty(bk_dirty), .bk_reset(bk_reset), .bk_err(bk_err)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct { bit rd; int lba; } req_t;
    req_t exp_q[$];

    int n_pass = 0, n_total = 0;
    int we_cnt = 0, rst_cnt = 0, addr_bad = 0, cur_sect = 0;
    int nsect_m = NSECT_MAX;
    bit sd_mute = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    // Reference model: sectors covered by an image of the given size.
    function automatic int model_nsect(input longint size);
        longint s = (size + 511) / 512;
        return (s > NSECT_MAX) ? NSECT_MAX : int'(s);
    endfunction

    task automatic exp_xfer(input bit rd);
        for (int i = 0; i < nsect_m; i++) exp_q.push_back('{rd, LBA_BASE + i});
    endtask

    task automatic mount(input int size);
        img_size = size; img_mounted = 1'b0; tick(); img_mounted = 1'b1; tick();
    endtask

    task automatic do_reset();
        RESET_n = 1'b0; img_mounted = 1'b0; tick(2); RESET_n = 1'b1; tick(2);
        nsect_m = NSECT_MAX;
    endtask

    task automatic wait_start(input string nm);
        int t = 0;
        while (!bk_busy && t < 200) begin tick(); t++; end
        chk({nm, "_start"}, bk_busy, 1);
    endtask

    task automatic wait_end(input string nm);
        int t = 0;
        while (bk_busy && t < 20000) begin tick(); t++; end
        chk({nm, "_end"}, bk_busy, 0);
    endtask

    task automatic pulse_dirty();
        dirty_in = 1'b1; tick(); dirty_in = 1'b0; tick();
    endtask

    // user_io model: acks each request after a random delay; 512 byte strobes for reads.
    initial begin : responder
        bit rd;
        sd_if.sd_ack = 1'b0; sd_if.sd_buff_addr = '0; sd_if.sd_buff_wr = 1'b0;
        forever begin
            tick();
            if (!sd_mute && RESET_n && (sd_if.sd_rd || sd_if.sd_wr) && !sd_if.sd_ack) begin
                rd = sd_if.sd_rd;
                tick($urandom_range(0, 3));
                sd_if.sd_ack = 1'b1;
                for (int i = 0; i < (rd ? 512 : 8); i++) begin
                    sd_if.sd_buff_addr = 9'(i); sd_if.sd_buff_wr = rd; tick();
                end
                sd_if.sd_buff_wr = 1'b0; sd_if.sd_ack = 1'b0;
            end
        end
    end

    // Monitor: pop expected request on every new sd_rd/sd_wr, count nvram writes.
    initial begin : monitor
        bit prev;
        bit req;
        req_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk_sys);
            req = sd_if.sd_rd | sd_if.sd_wr;
            if (req && !prev) begin
                if (exp_q.size() == 0) chk("unexpected_req", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("req_rd", sd_if.sd_rd, e.rd);
                    chk("req_wr", sd_if.sd_wr, !e.rd);
                    chk("req_lba", sd_if.sd_lba, e.lba);
                    cur_sect = e.lba - LBA_BASE;
                end
            end
            prev = req;
            if (bk_we) begin
                we_cnt++;
                if (int'(bk_addr) != cur_sect * 512 + int'(sd_if.sd_buff_addr)) addr_bad++;
            end
            if (bk_reset) rst_cnt++;
        end
    end

    initial begin : global_timeout
        #950000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin : stim
        int we0, r0, a0, busy_seen, t, sz;
        tick(3);
        chk("rst_sd_rd", sd_if.sd_rd, 0);
        chk("rst_sd_wr", sd_if.sd_wr, 0);
        chk("rst_lba", sd_if.sd_lba, LBA_BASE);
        chk("rst_ena", bk_ena, 0);
        chk("rst_busy", bk_busy, 0);
        chk("rst_dirty", bk_dirty, 0);
        chk("rst_reset", bk_reset, 0);
        chk("rst_err", bk_err, 0);
        chk("rst_we", bk_we, 0);
        RESET_n = 1'b1; tick(2);

        // Full 8 KB image load
        nsect_m = model_nsect(8192); exp_xfer(1);
        we0 = we_cnt; r0 = rst_cnt; a0 = addr_bad;
        mount(8192); wait_start("load8k"); wait_end("load8k"); tick(2);
        chk("load8k_we", we_cnt - we0, 512 * nsect_m);
        chk("load8k_reset", rst_cnt - r0, 1);
        chk("load8k_addr", addr_bad - a0, 0);
        chk("load8k_ena", bk_ena, 1);
        chk("load8k_err", bk_err, 0);
        chk("load8k_dirty", bk_dirty, 0);

        // Save with a further write landing mid-save
        pulse_dirty(); chk("dirty_set", bk_dirty, 1);
        exp_xfer(0); we0 = we_cnt;
        save_req = 1'b1; tick(); save_req = 1'b0;
        wait_start("save"); chk("save_start_clr", bk_dirty, 0);
        tick(20); pulse_dirty(); wait_end("save");
        chk("save_dirty_mid", bk_dirty, 1);
        chk("save_no_we", we_cnt - we0, 0);

        // Write-protected save is dropped
        img_readonly = 1'b1; save_req = 1'b1; tick(); save_req = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 30; i++) begin tick(); if (bk_busy) busy_seen++; end
        chk("ro_busy", busy_seen, 0); chk("ro_err", bk_err, 1); chk("ro_dirty", bk_dirty, 1);
        img_readonly = 1'b0;

        // Save requested while a load runs: runs after, with no nvram writes
        exp_xfer(1); exp_xfer(0); we0 = we_cnt; a0 = addr_bad;
        load_req = 1'b1; tick(); load_req = 1'b0;
        wait_start("ldsv_load"); tick($urandom_range(50, 3000));
        save_req = 1'b1; tick(); save_req = 1'b0;
        wait_end("ldsv_load"); wait_start("ldsv_save"); wait_end("ldsv_save");
        chk("ldsv_we", we_cnt - we0, 512 * nsect_m);
        chk("ldsv_addr", addr_bad - a0, 0);
        chk("ldsv_dirty", bk_dirty, 0);

        // Load and save in the same cycle: load only
        exp_xfer(1);
        load_req = 1'b1; save_req = 1'b1; tick(); load_req = 1'b0; save_req = 1'b0;
        wait_start("same_load"); wait_end("same_load");
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin tick(); if (bk_busy) busy_seen++; end
        chk("same_no_save", busy_seen, 0);
        chk("same_queue", exp_q.size(), 0);

        // Autosave on trigger rise while dirty
        pulse_dirty(); exp_xfer(0);
        autosave_trig = 1'b1; tick(); autosave_trig = 1'b0;
        wait_start("auto"); wait_end("auto");
        chk("auto_dirty", bk_dirty, 0);

        // Short image: 1536 B -> 3 sectors
        do_reset();
        nsect_m = model_nsect(1536); exp_xfer(1); we0 = we_cnt; r0 = rst_cnt;
        mount(1536); wait_start("short"); wait_end("short"); tick(2);
        chk("short_we", we_cnt - we0, 512 * nsect_m);
        chk("short_reset", rst_cnt - r0, 1);
        chk("short_err", bk_err, 1); chk("short_ena", bk_ena, 1);

        // Random image size, then a save covering the same sectors
        do_reset();
        sz = $urandom_range(1, 9000);
        nsect_m = model_nsect(sz); exp_xfer(1); we0 = we_cnt; a0 = addr_bad;
        mount(sz); wait_start("rnd"); wait_end("rnd"); tick(2);
        chk("rnd_we", we_cnt - we0, 512 * nsect_m);
        chk("rnd_addr", addr_bad - a0, 0);
        chk("rnd_err", bk_err, (nsect_m < NSECT_MAX) ? 1 : 0);
        pulse_dirty(); exp_xfer(0);
        save_req = 1'b1; tick(); save_req = 1'b0;
        wait_start("rnd_save"); wait_end("rnd_save");

        // Empty image disables backup
        mount(0); tick(3);
        chk("empty_ena", bk_ena, 0); chk("empty_busy", bk_busy, 0);

        // Watchdog: no ack ever arrives
        do_reset(); sd_mute = 1'b1;
        exp_q.push_back('{1'b1, LBA_BASE});
        mount(8192); wait_start("tmo"); chk("tmo_err_pre", bk_err, 0);
        t = 0;
        while (bk_busy && t < 3000) begin tick(); t++; end
        chk("tmo_window", (t >= (1 << TMO_W) - 24 && t <= (1 << TMO_W) + 16) ? 1 : 0, 1);
        chk("tmo_sd_rd", sd_if.sd_rd, 0); chk("tmo_err", bk_err, 1); chk("tmo_busy", bk_busy, 0);

        // Aborted save leaves the RAM marked dirty
        pulse_dirty(); exp_q.push_back('{1'b0, LBA_BASE});
        save_req = 1'b1; tick(); save_req = 1'b0;
        wait_start("tmo_save"); chk("tmo_save_clr", bk_dirty, 0);
        wait_end("tmo_save"); chk("tmo_save_dirty", bk_dirty, 1);

        // Asynchronous reset in the middle of a transfer
        sd_mute = 1'b0; nsect_m = NSECT_MAX; exp_xfer(1);
        load_req = 1'b1; tick(); load_req = 1'b0;
        t = 0;
        while (!sd_if.sd_ack && t < 300) begin tick(); t++; end
        chk("mid_ack_seen", sd_if.sd_ack, 1);
        tick(10); #2; RESET_n = 1'b0; #1;
        chk("mid_sd_rd", sd_if.sd_rd, 0); chk("mid_sd_wr", sd_if.sd_wr, 0);
        chk("mid_busy", bk_busy, 0); chk("mid_ena", bk_ena, 0);
        chk("mid_we", bk_we, 0); chk("mid_err", bk_err, 0);
        chk("mid_lba", sd_if.sd_lba, LBA_BASE);
        exp_q.delete();
        t = 0;
        while (sd_if.sd_ack && t < 700) begin tick(); t++; end
        img_mounted = 1'b0; RESET_n = 1'b1; tick(5);
        chk("final_queue", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
